ps2_scancode_decoder: RTL and testbench
=======================================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have port: CLOCK_50  in  1  system clock, 50 MHz; all logic on its rising edge.
REQ-002 SHALL have port: Resetn  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: key_action  in  1  emulated PS/2 byte strobe; rising edge marks new scan_code.
REQ-004 SHALL have port: scan_code  in  8  PS/2 set-2 byte, valid when key_action rises.
REQ-005 SHALL have port: ps2_lock_control  out  3  keyboard lock LEDs: [0] scroll, [1] num, [2] caps.
REQ-006 SHALL have port: ev_valid  out  1  event FIFO non-empty.
REQ-007 SHALL have port: ev_ready  in  1  consumer pops head event when ev_valid && ev_ready.
REQ-008 SHALL have port: ev_code  out  8  head event key code (prefixes stripped).
REQ-009 SHALL have port: ev_ext  out  1  head event carried E0 prefix.
REQ-010 SHALL have port: ev_break  out  1  head event is a release (F0 prefix).
REQ-011 SHALL have port: overflow  out  1  sticky: event dropped because FIFO full.

Function
REQ-012 SHALL register key_action once and detect a byte strobe as key_action && !key_action_q; one byte per rising edge.
REQ-013 SHALL run prefix FSM, states IDLE, E0, F0, E0F0; transitions only on a byte strobe.
REQ-014 IDLE: 0xE0 -> E0; 0xF0 -> F0; 0xAA, 0xEE, 0xFA, 0xFE, 0x00, 0xFF, 0xE1 discarded, stay IDLE; other byte -> emit make (ext=0), stay IDLE.
REQ-015 E0: 0xF0 -> E0F0; 0xE0 stays E0; other byte -> emit make (ext=1) -> IDLE.
REQ-016 F0: any byte except 0xE0/0xF0 -> emit break (ext=0) -> IDLE; 0xE0 or 0xF0 -> IDLE, no event.
REQ-017 E0F0: any byte except 0xE0/0xF0 -> emit break (ext=1) -> IDLE; 0xE0 or 0xF0 -> IDLE, no event.
REQ-018 SHALL push emitted event {ext, break, code} into a 4-entry FIFO in the strobe cycle; ev_valid high on the next edge (latency 1 cycle from strobe).
REQ-019 SHALL present FIFO head on ev_code/ev_ext/ev_break; outputs are don't-care when ev_valid=0.
REQ-020 Push while full and no pop in same cycle: event dropped, overflow set to 1 and held until reset.
REQ-021 Push and pop in same cycle when full: both occur, no drop, count unchanged.
REQ-022 Push and pop in same cycle when count is 1: new event becomes head next cycle, ev_valid stays 1.
REQ-023 Pointers wrap modulo 4; count range 0..4.
REQ-024 Lock toggles on non-extended make only: 0x58 toggles caps, 0x77 num, 0x7E scroll; visible on ps2_lock_control one cycle after strobe.
REQ-025 SHALL track held state per lock key; repeated make while held (auto-repeat) does not toggle; matching break clears held.
REQ-026 Lock toggling SHALL occur even when the event is dropped on overflow.
REQ-027 Extended codes equal to 0x58/0x77/0x7E SHALL NOT toggle locks.

Reset
REQ-028 Resetn low SHALL immediately force: FSM IDLE, FIFO empty (ev_valid=0), overflow=0, ps2_lock_control=3'b000, held flags 0, key_action_q=0.
REQ-029 Reset mid-sequence (e.g. after E0) SHALL discard the partial prefix; first byte after release is decoded from IDLE.
REQ-030 ev_code/ev_ext/ev_break SHALL read 0 during reset.

Structure
REQ-031 Package ps2_pkg SHALL hold: prefix constants (0xE0, 0xF0), discard-code list, lock key codes, lock bit indices, FSM state enumeration, FIFO depth (4), event width (10).
REQ-032 FIFO SHALL be one sub-module ps2_event_fifo (10-bit wide, depth 4, valid/ready pop, push with full flag); FSM and lock logic in the top.

Verification
REQ-033 Bytes 0x1C -> one event code=0x1C ext=0 break=0, ev_valid one cycle after strobe.
REQ-034 Bytes E0,F0,0x75 -> one event code=0x75 ext=1 break=1; no events for prefixes.
REQ-035 Bytes 0x58,0x58,F0,0x58,0x58 with ev_ready=1 -> ps2_lock_control: 100, stays 100, then 000 after final make; 4 events.
REQ-036 ev_ready=0, five makes 0x15,0x1D,0x24,0x2D,0x2C -> overflow=1, FIFO pops 0x15,0x1D,0x24,0x2D in order, 0x2C lost.
REQ-037 Byte E0 then Resetn pulse low then 0x1C -> event code=0x1C ext=0; locks 000, overflow 0.
REQ-038 FIFO full, ev_ready=1 in same cycle as strobe of 0x1B -> no overflow, 0x1B arrives as fourth entry after pop.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, types and helpers for the PS/2 set-2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] PREFIX_E0 = 8'hE0;
    localparam logic [7:0] PREFIX_F0 = 8'hF0;

    // Keyboard status/ack bytes and the E1 (Pause) prefix are never turned into events.
    localparam logic [7:0] DISCARD_BAT_OK  = 8'hAA;
    localparam logic [7:0] DISCARD_ECHO    = 8'hEE;
    localparam logic [7:0] DISCARD_ACK     = 8'hFA;
    localparam logic [7:0] DISCARD_RESEND  = 8'hFE;
    localparam logic [7:0] DISCARD_ERR_LO  = 8'h00;
    localparam logic [7:0] DISCARD_ERR_HI  = 8'hFF;
    localparam logic [7:0] DISCARD_E1      = 8'hE1;

    localparam logic [7:0] LOCK_CODE_CAPS   = 8'h58;
    localparam logic [7:0] LOCK_CODE_NUM    = 8'h77;
    localparam logic [7:0] LOCK_CODE_SCROLL = 8'h7E;

    localparam int LOCK_BIT_SCROLL = 0;
    localparam int LOCK_BIT_NUM    = 1;
    localparam int LOCK_BIT_CAPS   = 2;

    localparam int FIFO_DEPTH = 4;
    localparam int EV_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic is_discard(input logic [7:0] code);
        return (code == DISCARD_BAT_OK) || (code == DISCARD_ECHO) ||
               (code == DISCARD_ACK)    || (code == DISCARD_RESEND) ||
               (code == DISCARD_ERR_LO) || (code == DISCARD_ERR_HI) ||
               (code == DISCARD_E1);
    endfunction

    function automatic logic is_prefix(input logic [7:0] code);
        return (code == PREFIX_E0) || (code == PREFIX_F0);
    endfunction

    // One-hot mask in ps2_lock_control bit order; zero for non-lock keys.
    function automatic logic [2:0] lock_mask(input logic [7:0] code);
        logic [2:0] m;
        m = 3'b000;
        if (code == LOCK_CODE_SCROLL) m[LOCK_BIT_SCROLL] = 1'b1;
        if (code == LOCK_CODE_NUM)    m[LOCK_BIT_NUM]    = 1'b1;
        if (code == LOCK_CODE_CAPS)   m[LOCK_BIT_CAPS]   = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small event FIFO: push with full flag, valid/ready pop, head shown combinationally.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = EV_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only if the head leaves in the same cycle.
    assign do_pop  = valid_o && ready_i;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    // Pointer/count registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset because the head is only meaningful while valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, lock-LED tracking and a small event queue.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  IDLE    | no prefix pending
//  E0      | extended prefix seen
//  F0      | break prefix seen
//  E0F0    | extended break prefix seen
module ps2_scancode_decoder
    import ps2_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       key_action,
    input  logic [7:0] scan_code,
    output logic [2:0] ps2_lock_control,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       overflow
);

    logic       key_action_q;
    logic       strobe;
    ps2_state_t state_q, state_d;
    logic       emit, emit_ext, emit_brk;
    logic [2:0] locks_q, locks_d;
    logic [2:0] held_q, held_d;
    logic [2:0] mask;
    logic       overflow_q, overflow_d;
    logic       fifo_full;
    logic       fifo_valid;
    ps2_event_t push_ev;
    ps2_event_t head_ev;

    assign strobe = key_action && !key_action_q;

    // Prefix FSM: next state and event emission, only on a byte strobe.
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == PREFIX_E0)      state_d = ST_E0;
                    else if (scan_code == PREFIX_F0) state_d = ST_F0;
                    else if (!is_discard(scan_code)) emit    = 1'b1;
                end
                ST_E0: begin
                    if (scan_code == PREFIX_F0) begin
                        state_d = ST_E0F0;
                    end else if (scan_code != PREFIX_E0) begin
                        state_d  = ST_IDLE;
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                ST_F0: begin
                    state_d  = ST_IDLE;
                    emit     = !is_prefix(scan_code);
                    emit_brk = 1'b1;
                end
                ST_E0F0: begin
                    state_d  = ST_IDLE;
                    emit     = !is_prefix(scan_code);
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Lock tracking: first non-extended make toggles, auto-repeat is ignored until the break.
    always_comb begin
        locks_d = locks_q;
        held_d  = held_q;
        mask    = lock_mask(scan_code);
        if (emit && !emit_ext) begin
            if (!emit_brk) begin
                locks_d = locks_q ^ (mask & ~held_q);
                held_d  = held_q | mask;
            end else begin
                held_d  = held_q & ~mask;
            end
        end
    end

    // Overflow is sticky once any event is lost to a full queue.
    always_comb begin
        overflow_d = overflow_q;
        if (emit && fifo_full && !(fifo_valid && ev_ready)) overflow_d = 1'b1;
    end

    // Decoder state registers.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            key_action_q <= 1'b0;
            state_q      <= ST_IDLE;
            locks_q      <= 3'b000;
            held_q       <= 3'b000;
            overflow_q   <= 1'b0;
        end else begin
            key_action_q <= key_action;
            state_q      <= state_d;
            locks_q      <= locks_d;
            held_q       <= held_d;
            overflow_q   <= overflow_d;
        end
    end

    assign push_ev.ext  = emit_ext;
    assign push_ev.brk  = emit_brk;
    assign push_ev.code = scan_code;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk_i       (CLOCK_50),
        .rst_n_i     (Resetn),
        .push_i      (emit),
        .push_data_i (push_ev),
        .full_o      (fifo_full),
        .valid_o     (fifo_valid),
        .ready_i     (ev_ready),
        .data_o      (head_ev)
    );

    // Head fields are forced to zero when empty so they read 0 throughout reset.
    assign ev_valid         = fifo_valid;
    assign ev_code          = fifo_valid ? head_ev.code : 8'h00;
    assign ev_ext           = fifo_valid ? head_ev.ext  : 1'b0;
    assign ev_break         = fifo_valid ? head_ev.brk  : 1'b0;
    assign ps2_lock_control = locks_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for the PS/2 scan-code decoder.
module tb_ps2_scancode_decoder;

    logic       CLOCK_50;
    logic       Resetn;
    logic       key_action;
    logic [7:0] scan_code;
    logic [2:0] ps2_lock_control;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    logic [9:0] exp_q [$];
    logic [9:0] exp_ev;

    ps2_scancode_decoder dut (
        .CLOCK_50         (CLOCK_50),
        .Resetn           (Resetn),
        .key_action       (key_action),
        .scan_code        (scan_code),
        .ps2_lock_control (ps2_lock_control),
        .ev_valid         (ev_valid),
        .ev_ready         (ev_ready),
        .ev_code          (ev_code),
        .ev_ext           (ev_ext),
        .ev_break         (ev_break),
        .overflow         (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every accepted head event is compared with the oldest expectation.
    always @(negedge CLOCK_50) begin
        if (Resetn && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: got %h expected none", {ev_ext, ev_break, ev_code});
            end else begin
                exp_ev = exp_q.pop_front();
                chk("event", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, exp_ev});
            end
        end
    end

    // Leaves time at #1 after the edge on which the strobe is registered.
    task automatic strobe_byte(input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        scan_code  = b;
        key_action = 1'b1;
        @(posedge CLOCK_50); #1;
        key_action = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        strobe_byte(b);
        @(posedge CLOCK_50); #1;
    endtask

    task automatic drain(input string name);
        ev_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge CLOCK_50);
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_valid_low"}, ev_valid, 0);
    endtask

    initial begin
        Resetn     = 1'b0;
        key_action = 1'b0;
        scan_code  = 8'h00;
        ev_ready   = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_valid", ev_valid, 0);
        chk("rst_head", {ev_ext, ev_break, ev_code}, 10'h000);
        chk("rst_locks", ps2_lock_control, 3'b000);
        chk("rst_overflow", overflow, 0);
        Resetn = 1'b1;

        // Plain make with one-cycle latency.
        @(posedge CLOCK_50); #1;
        scan_code  = 8'h1C;
        key_action = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        chk("make_before_edge", ev_valid, 0);
        @(posedge CLOCK_50); #1;
        key_action = 1'b0;
        chk("make_latency", ev_valid, 1);
        @(posedge CLOCK_50); #1;

        // Extended break; prefixes produce nothing.
        send_byte(8'hE0);
        send_byte(8'hF0);
        exp_q.push_back({2'b11, 8'h75});
        send_byte(8'h75);

        // Discarded bytes, aborted F0 E0 prefix, then a plain make from IDLE.
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'hF0);
        send_byte(8'hE0);
        exp_q.push_back({2'b00, 8'h1B});
        send_byte(8'h1B);
        drain("prefix");

        // Caps lock: toggle, auto-repeat, release, toggle again.
        exp_q.push_back({2'b00, 8'h58});
        strobe_byte(8'h58);
        chk("caps_first", ps2_lock_control, 3'b100);
        exp_q.push_back({2'b00, 8'h58});
        send_byte(8'h58);
        chk("caps_repeat", ps2_lock_control, 3'b100);
        send_byte(8'hF0);
        exp_q.push_back({2'b01, 8'h58});
        send_byte(8'h58);
        chk("caps_break", ps2_lock_control, 3'b100);
        exp_q.push_back({2'b00, 8'h58});
        strobe_byte(8'h58);
        chk("caps_second", ps2_lock_control, 3'b000);

        // Extended lock code ignored; num lock toggles.
        send_byte(8'hE0);
        exp_q.push_back({2'b10, 8'h77});
        send_byte(8'h77);
        chk("ext_num_no_toggle", ps2_lock_control, 3'b000);
        exp_q.push_back({2'b00, 8'h77});
        send_byte(8'h77);
        chk("num_toggle", ps2_lock_control, 3'b010);
        send_byte(8'hF0);
        exp_q.push_back({2'b01, 8'h77});
        send_byte(8'h77);
        drain("locks");

        // Overflow: fifth event dropped, lock still toggles on a dropped make.
        ev_ready = 1'b0;
        exp_q.push_back({2'b00, 8'h15}); send_byte(8'h15);
        exp_q.push_back({2'b00, 8'h1D}); send_byte(8'h1D);
        exp_q.push_back({2'b00, 8'h24}); send_byte(8'h24);
        exp_q.push_back({2'b00, 8'h2D}); send_byte(8'h2D);
        chk("full_no_overflow", overflow, 0);
        send_byte(8'h2C);
        chk("overflow_set", overflow, 1);
        send_byte(8'h7E);
        chk("drop_lock_toggle", ps2_lock_control, 3'b011);
        drain("overflow");
        chk("overflow_sticky", overflow, 1);

        // Reset in the middle of an E0 prefix.
        send_byte(8'hE0);
        #3;
        Resetn = 1'b0;
        #1;
        chk("async_rst_overflow", overflow, 0);
        chk("async_rst_locks", ps2_lock_control, 3'b000);
        chk("async_rst_valid", ev_valid, 0);
        @(posedge CLOCK_50); #1;
        Resetn = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        send_byte(8'h1C);
        chk("post_rst_locks", ps2_lock_control, 3'b000);
        chk("post_rst_overflow", overflow, 0);
        drain("reset");

        // Full FIFO with a pop in the strobe cycle: no drop.
        ev_ready = 1'b0;
        exp_q.push_back({2'b00, 8'h11}); send_byte(8'h11);
        exp_q.push_back({2'b00, 8'h12}); send_byte(8'h12);
        exp_q.push_back({2'b00, 8'h13}); send_byte(8'h13);
        exp_q.push_back({2'b00, 8'h14}); send_byte(8'h14);
        @(posedge CLOCK_50); #1;
        scan_code  = 8'h1B;
        key_action = 1'b1;
        ev_ready   = 1'b1;
        exp_q.push_back({2'b00, 8'h1B});
        @(posedge CLOCK_50); #1;
        key_action = 1'b0;
        ev_ready   = 1'b0;
        chk("full_pushpop_overflow", overflow, 0);
        chk("full_pushpop_valid", ev_valid, 1);
        chk("full_pushpop_queue", exp_q.size(), 4);
        drain("full_pushpop");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
